// File: rtl/asteroids_pkg.sv
`default_nettype none
// ============================================================================
// asteroids_pkg: shared defaults and types for the torpedo launch scheduler.
// Revision 1.0
// ============================================================================
package asteroids_pkg;

  localparam int T_NUM_DEFAULT           = 4;
  localparam int TTL_FRAMES_DEFAULT      = 60;
  localparam int COOLDOWN_FRAMES_DEFAULT = 8;

  localparam int SLOT_IDX_W = (T_NUM_DEFAULT > 1) ? $clog2(T_NUM_DEFAULT) : 1;

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

endpackage : asteroids_pkg
`default_nettype wire

// File: rtl/torpedo_launch_scheduler_rr_free_slot_picker.sv
`default_nettype none
// ============================================================================
// rr_free_slot_picker: finds the first free slot at or after ptr_i (mod T_NUM).
// Revision 1.0
// ============================================================================
module rr_free_slot_picker
  import asteroids_pkg::*;
#(
  parameter int T_NUM = T_NUM_DEFAULT,
  parameter int IDX_W = (T_NUM > 1) ? $clog2(T_NUM) : 1
) (
  input  logic [T_NUM-1:0] free_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] slot_o
);

  localparam int SUM_W = IDX_W + 1;

  logic [T_NUM-1:0] w_rot;
  logic [IDX_W-1:0] w_off;
  logic [SUM_W-1:0] w_sum;

  always_comb begin
    // Rotate so the search origin lands on bit 0, then take the lowest set bit.
    w_rot   = T_NUM'({free_i, free_i} >> ptr_i);
    found_o = 1'b0;
    w_off   = '0;
    for (int k = T_NUM - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        found_o = 1'b1;
        w_off   = IDX_W'(k);
      end
    end
    w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    if (w_sum >= SUM_W'(T_NUM)) begin
      w_sum = w_sum - SUM_W'(T_NUM);
    end
    slot_o = w_sum[IDX_W-1:0];
  end

endmodule : rr_free_slot_picker
`default_nettype wire

// File: rtl/torpedo_launch_scheduler.sv
`default_nettype none
// ============================================================================
// torpedo_launch_scheduler: round-robin torpedo slot allocator with launch
// cooldown and per-slot time-to-live. Optional macro TORPEDO_AUTOFIRE_EN makes
// a held fire button re-request every time the cooldown elapses.
// Revision 1.0
// ============================================================================
module torpedo_launch_scheduler
  import asteroids_pkg::*;
#(
  parameter int T_NUM           = T_NUM_DEFAULT,
  parameter int TTL_FRAMES      = TTL_FRAMES_DEFAULT,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic                       fire,
  input  logic                       enable,
  input  logic [T_NUM-1:0]           slot_hit,
  output logic [T_NUM-1:0]           launch,
  output logic [T_NUM-1:0]           active,
  output logic [$clog2(T_NUM+1)-1:0] free_cnt
);

  localparam int IDX_W = (T_NUM > 1) ? $clog2(T_NUM) : 1;
  localparam int TTL_W = $clog2(TTL_FRAMES + 1);
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int CNT_W = $clog2(T_NUM + 1);

  logic             fire_d_q, fire_d_d;
  logic             pend_q, pend_d;
  logic [CD_W-1:0]  cooldown_q, cooldown_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [T_NUM-1:0] launch_q, launch_d;
  logic [T_NUM-1:0] active_q, active_d;
  logic [TTL_W-1:0] ttl_q [T_NUM];
  logic [TTL_W-1:0] ttl_d [T_NUM];

  logic [T_NUM-1:0] w_free;
  logic             w_found;
  logic [IDX_W-1:0] w_slot;
  logic             w_req;
  logic             w_grant;

  assign w_free = ~active_q;

  rr_free_slot_picker #(
    .T_NUM (T_NUM),
    .IDX_W (IDX_W)
  ) u_picker (
    .free_i  (w_free),
    .ptr_i   (rr_ptr_q),
    .found_o (w_found),
    .slot_o  (w_slot)
  );

  always_comb begin
`ifdef TORPEDO_AUTOFIRE_EN
    w_req = enable & fire & (~fire_d_q | ((cooldown_q == '0) & ~pend_q));
`else
    w_req = enable & fire & ~fire_d_q;
`endif
    w_grant = pend_q & enable & (cooldown_q == '0) & w_found;

    fire_d_d = fire;

    // A grant or a new request outranks the frame-boundary expiry of a request.
    pend_d = pend_q;
    if (!enable || w_grant) begin
      pend_d = 1'b0;
    end else if (w_req) begin
      pend_d = 1'b1;
    end else if (frame_tick) begin
      pend_d = 1'b0;
    end

    cooldown_d = cooldown_q;
    if (w_grant) begin
      cooldown_d = CD_W'(COOLDOWN_FRAMES);
    end else if (frame_tick && (cooldown_q != '0)) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end

    rr_ptr_d = rr_ptr_q;
    if (w_grant) begin
      rr_ptr_d = (w_slot == IDX_W'(T_NUM - 1)) ? '0 : w_slot + IDX_W'(1);
    end

    launch_d = '0;
    active_d = active_q;
    for (int i = 0; i < T_NUM; i++) begin
      ttl_d[i] = ttl_q[i];
      if (w_grant && (w_slot == IDX_W'(i))) begin
        launch_d[i] = 1'b1;
        active_d[i] = 1'b1;
        ttl_d[i]    = TTL_W'(TTL_FRAMES);
      end else if (active_q[i]) begin
        if (slot_hit[i]) begin
          active_d[i] = 1'b0;
          ttl_d[i]    = '0;
        end else if (frame_tick) begin
          ttl_d[i] = ttl_q[i] - TTL_W'(1);
          if (ttl_q[i] == TTL_W'(1)) begin
            active_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_d_q   <= 1'b0;
      pend_q     <= 1'b0;
      cooldown_q <= '0;
      rr_ptr_q   <= '0;
      launch_q   <= '0;
      active_q   <= '0;
      for (int i = 0; i < T_NUM; i++) begin
        ttl_q[i] <= '0;
      end
    end else begin
      fire_d_q   <= fire_d_d;
      pend_q     <= pend_d;
      cooldown_q <= cooldown_d;
      rr_ptr_q   <= rr_ptr_d;
      launch_q   <= launch_d;
      active_q   <= active_d;
      for (int i = 0; i < T_NUM; i++) begin
        ttl_q[i] <= ttl_d[i];
      end
    end
  end

  assign launch   = launch_q;
  assign active   = active_q;
  assign free_cnt = CNT_W'($countones(w_free));

endmodule : torpedo_launch_scheduler
`default_nettype wire

// File: tb/tb_torpedo_launch_scheduler.sv
`default_nettype none
// ============================================================================
// tb_torpedo_launch_scheduler: vector table, directed scenarios and random
// stimulus against a frame-level reference model of the torpedo scheduler.
// Revision 1.0
// ============================================================================
module tb_torpedo_launch_scheduler;

  localparam int T   = 4;
  localparam int TTL = 60;
  localparam int CD  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] slot_hit = '0;
  logic [3:0] launch;
  logic [3:0] active;
  logic [2:0] free_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_launch = 0;
  int frame_no = 0;
  int launch_slots[$];
  int launch_frames[$];

  always #5 clk = ~clk;

  torpedo_launch_scheduler #(
    .T_NUM           (T),
    .TTL_FRAMES      (TTL),
    .COOLDOWN_FRAMES (CD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .fire       (fire),
    .enable     (enable),
    .slot_hit   (slot_hit),
    .launch     (launch),
    .active     (active),
    .free_cnt   (free_cnt)
  );

  // Reference model: slots hold "frames left to live"; a request waits at most
  // until the next frame boundary; grants search circularly from the pointer.
  bit         m_act[T];
  int         m_life[T];
  bit         m_pend;
  bit         m_fprev;
  int         m_cd;
  int         m_ptr;
  logic [3:0] m_launch;

  task automatic model_step(input bit rst, input bit ft, input bit fi, input bit en,
                            input logic [3:0] hit);
    int  s;
    bit  req;
    if (rst) begin
      for (int i = 0; i < T; i++) begin
        m_act[i]  = 0;
        m_life[i] = 0;
      end
      m_pend = 0; m_fprev = 0; m_cd = 0; m_ptr = 0; m_launch = '0;
      return;
    end
    s = -1;
    if (m_pend && en && m_cd == 0) begin
      for (int k = 0; k < T; k++) begin
        if (s < 0 && !m_act[(m_ptr + k) % T]) s = (m_ptr + k) % T;
      end
    end
    req = en && fi && !m_fprev;
`ifdef TORPEDO_AUTOFIRE_EN
    req = req || (en && fi && m_cd == 0 && !m_pend);
`endif
    m_launch = '0;
    for (int i = 0; i < T; i++) begin
      if (i == s) begin
        m_act[i] = 1; m_life[i] = TTL; m_launch[i] = 1'b1;
      end else if (m_act[i]) begin
        if (hit[i]) m_act[i] = 0;
        else if (ft) begin
          m_life[i] = m_life[i] - 1;
          if (m_life[i] == 0) m_act[i] = 0;
        end
      end
    end
    if (s >= 0) begin
      m_cd = CD; m_ptr = (s + 1) % T;
    end else if (ft && m_cd > 0) m_cd = m_cd - 1;
    if (!en || s >= 0) m_pend = 0;
    else if (req) m_pend = 1;
    else if (ft) m_pend = 0;
    m_fprev = fi;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < T; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic cycle();
    logic [3:0] ma;
    int         mfree;
    @(posedge clk);
    model_step(reset, frame_tick, fire, enable, slot_hit);
    #1;
    if (frame_tick && !reset) frame_no++;
    ma = '0; mfree = T;
    for (int i = 0; i < T; i++) if (m_act[i]) begin ma[i] = 1'b1; mfree--; end
    chk("model_launch", int'(launch), int'(m_launch));
    chk("model_active", int'(active), int'(ma));
    chk("model_free_cnt", int'(free_cnt), mfree);
    if (launch != '0) begin
      n_launch++;
      launch_slots.push_back(onehot_idx(launch));
      launch_frames.push_back(frame_no);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic frame();
    idle(3);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic press();
    fire = 1'b1;
    cycle();
    fire = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; fire = 1'b0; frame_tick = 1'b0; enable = 1'b1; slot_hit = '0;
    cycle();
    reset = 1'b0;
    n_launch = 0; frame_no = 0;
    launch_slots.delete();
    launch_frames.delete();
  endtask

  typedef struct {
    bit         rst, ft, fi, en;
    logic [3:0] hit;
    logic [3:0] e_launch;
    logic [3:0] e_active;
    logic [2:0] e_free;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input bit rst, input bit ft, input bit fi, input bit en,
                         input logic [3:0] hit, input logic [3:0] el,
                         input logic [3:0] ea, input logic [2:0] ef);
    vec_t v;
    v.rst = rst; v.ft = ft; v.fi = fi; v.en = en; v.hit = hit;
    v.e_launch = el; v.e_active = ea; v.e_free = ef;
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fell;
    int base;
    //       rst ft fi en hit    launch  active  free
    add_vec(1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 3'd4); // reset state
    add_vec(0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 3'd4);
    add_vec(0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 3'd4); // rise -> pending
    add_vec(0, 0, 1, 1, 4'h0, 4'h1, 4'h1, 3'd3); // grant slot 0
    add_vec(0, 0, 0, 1, 4'h0, 4'h0, 4'h1, 3'd3); // single-cycle pulse
    add_vec(0, 0, 1, 1, 4'h0, 4'h0, 4'h1, 3'd3); // request during cooldown
    add_vec(0, 0, 0, 1, 4'h0, 4'h0, 4'h1, 3'd3);
    add_vec(0, 1, 0, 1, 4'h0, 4'h0, 4'h1, 3'd3); // frame tick drops request
    add_vec(0, 0, 0, 1, 4'h1, 4'h0, 4'h0, 3'd4); // hit frees slot 0
    add_vec(0, 0, 0, 1, 4'h2, 4'h0, 4'h0, 3'd4); // hit on idle slot ignored
    add_vec(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 3'd4); // disabled press
    add_vec(0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 3'd4); // held, not a rising edge
    add_vec(0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 3'd4);
    add_vec(0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 3'd4); // cooldown still running
    add_vec(1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 3'd4);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; frame_tick = vq[i].ft; fire = vq[i].fi;
      enable = vq[i].en; slot_hit = vq[i].hit;
      cycle();
      chk($sformatf("vec%0d_launch", i), int'(launch), int'(vq[i].e_launch));
      chk($sformatf("vec%0d_active", i), int'(active), int'(vq[i].e_active));
      chk($sformatf("vec%0d_free", i), int'(free_cnt), int'(vq[i].e_free));
    end

    // Launch latency: fire high during cycle 10 -> launch during cycle 12 only.
    do_reset();
    idle(9);
    fire = 1'b1; cycle(); fire = 1'b0;
    chk("lat_cycle11", int'(launch), 0);
    cycle();
    chk("lat_cycle12", int'(launch), 1);
    cycle();
    chk("lat_cycle13", int'(launch), 0);
    chk("lat_active", int'(active), 1);
    chk("lat_free", int'(free_cnt), 3);

    // Round robin over four presses; fifth press with all slots busy is dropped.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      press();
      repeat (9) frame();
    end
    chk("rr_count", n_launch, 4);
    for (int p = 0; p < 4 && p < launch_slots.size(); p++)
      chk($sformatf("rr_slot%0d", p), launch_slots[p], p);
    press();
    idle(3);
    chk("full_no_launch", n_launch, 4);
    chk("full_free_cnt", int'(free_cnt), 0);
    frame();
    slot_hit = 4'b0100; cycle(); slot_hit = '0;
    idle(4);
    chk("full_not_buffered", n_launch, 4);
    chk("full_after_hit", int'(active), 4'b1011);

    // Cooldown: press 3 frames after a launch is lost, press at frame 9 fires.
    do_reset();
    press();
    repeat (3) frame();
    press();
    idle(3);
    chk("cd_blocked", n_launch, 1);
    repeat (6) frame();
    press();
    idle(2);
    chk("cd_elapsed", n_launch, 2);
    if (launch_slots.size() >= 2) chk("cd_second_slot", launch_slots[1], 1);

    // Time-to-live expiry on the 60th frame tick.
    do_reset();
    press(); idle(1);
    fell = 0;
    for (int f = 1; f <= 70 && fell == 0; f++) begin
      frame();
      if (!active[0]) fell = f;
    end
    chk("ttl_expiry_tick", fell, TTL);

    // Hit coincident with the 20th frame tick clears the slot on that edge.
    do_reset();
    press(); idle(1);
    repeat (19) frame();
    chk("hit_before", int'(active[0]), 1);
    idle(3);
    frame_tick = 1'b1; slot_hit = 4'b0001; cycle();
    frame_tick = 1'b0; slot_hit = '0;
    chk("hit_with_tick", int'(active[0]), 0);

    // Disabled for 20 frames with fire toggling: no launches, aging continues.
    do_reset();
    press(); idle(1);
    repeat (40) frame();
    base = n_launch;
    enable = 1'b0;
    fell = 0;
    for (int c = 0; c < 80; c++) begin
      fire = (c % 2 == 0);
      frame_tick = (c % 4 == 3);
      cycle();
      if (!active[0] && fell == 0) fell = frame_no;
    end
    fire = 1'b0; frame_tick = 1'b0; enable = 1'b1;
    chk("dis_no_launch", n_launch, base);
    chk("dis_expiry_tick", fell, TTL);

    // Holding the button for 40 frames from idle.
    do_reset();
    fire = 1'b1;
    repeat (40) frame();
    fire = 1'b0;
    idle(2);
`ifdef TORPEDO_AUTOFIRE_EN
    chk("hold_count", n_launch, 4);
    for (int p = 0; p < 4 && p < launch_frames.size(); p++)
      chk($sformatf("hold_frame%0d", p), launch_frames[p], p * CD);
`else
    chk("hold_count", n_launch, 1);
    if (launch_frames.size() >= 1) chk("hold_frame0", launch_frames[0], 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      fire       = ($urandom_range(0, 2) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      slot_hit   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      cycle();
    end
    reset = 1'b0; frame_tick = 1'b0; fire = 1'b0; slot_hit = '0; enable = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_torpedo_launch_scheduler
`default_nettype wire
